// File: rtl/catch_pkg.sv
// Shared types and defaults for the capture-attempt judge.
// Also used by the LFSR that later drives wild-encounter randomness.
package catch_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHAKE  = 2'd1,
        S_PAUSE  = 2'd2,
        S_RESULT = 2'd3
    } catch_state_e;

    // Fibonacci taps 16, 14, 13, 11 as bit positions 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int          DEF_SHAKE_FRAMES = 16;
    localparam int          DEF_NUM_SHAKES   = 3;
    localparam logic [15:0] DEF_LFSR_SEED    = 16'hACE1;

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, one step per clock.
// Shifts left with the tap parity entering at bit 0.
module lfsr16 import catch_pkg::*; #(
    parameter logic [15:0] SEED = DEF_LFSR_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else begin
            q <= {q[14:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/catch_judge.sv
// Capture-attempt judge: frame-timed ball shakes with an LFSR draw per shake,
// then a held catch/escape result until the game FSM acknowledges it.
module catch_judge import catch_pkg::*; #(
    parameter int          SHAKE_FRAMES = DEF_SHAKE_FRAMES,
    parameter int          NUM_SHAKES   = DEF_NUM_SHAKES,
    parameter logic [15:0] LFSR_SEED    = DEF_LFSR_SEED
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_refresh,
    input  logic       i_collision_done,
    input  logic [7:0] i_catch_rate,
    input  logic       i_ack,
    output logic       o_busy,
    output logic       o_shake_left,
    output logic       o_shake_right,
    output logic [1:0] o_shake_idx,
    output logic       o_result_valid,
    output logic       o_caught
);

    localparam int             FW         = $clog2(SHAKE_FRAMES);
    localparam logic [FW-1:0]  LAST_FRAME = FW'(SHAKE_FRAMES - 1);
    localparam logic [FW-1:0]  HALF_FRAME = FW'(SHAKE_FRAMES / 2);
    localparam logic [1:0]     LAST_SHAKE = 2'(NUM_SHAKES - 1);

    catch_state_e  state_q;
    logic [FW-1:0] frame_q;
    logic [1:0]    idx_q;
    logic [7:0]    sample_q;
    logic          caught_q;
    logic          cd_q;
    logic          cd_qq;
    logic [15:0]   lfsr;
    logic          unused_lfsr_hi;
    logic          cd_rise;
    logic          frame_end;
    logic          shake_pass;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .q     (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr[15:8];
    assign cd_rise        = cd_q & ~cd_qq;
    assign frame_end      = i_refresh && (frame_q == LAST_FRAME);
    assign shake_pass     = (sample_q < i_catch_rate) || (i_catch_rate == 8'hFF);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            frame_q  <= '0;
            idx_q    <= '0;
            sample_q <= '0;
            caught_q <= 1'b0;
            cd_q     <= 1'b0;
            cd_qq    <= 1'b0;
        end else begin
            cd_q  <= i_collision_done;
            cd_qq <= cd_q;
            unique case (state_q)
                S_IDLE: begin
                    if (cd_rise) begin
                        state_q  <= S_SHAKE;
                        frame_q  <= '0;
                        idx_q    <= '0;
                        sample_q <= lfsr[7:0];
                    end
                end
                S_SHAKE: begin
                    if (frame_end) begin
                        frame_q <= '0;
                        if (!shake_pass) begin
                            state_q  <= S_RESULT;
                            caught_q <= 1'b0;
                        end else if (idx_q == LAST_SHAKE) begin
                            state_q  <= S_RESULT;
                            caught_q <= 1'b1;
                        end else begin
                            state_q <= S_PAUSE;
                        end
                    end else if (i_refresh) begin
                        frame_q <= frame_q + 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (frame_end) begin
                        state_q  <= S_SHAKE;
                        frame_q  <= '0;
                        idx_q    <= idx_q + 1'b1;
                        sample_q <= lfsr[7:0];
                    end else if (i_refresh) begin
                        frame_q <= frame_q + 1'b1;
                    end
                end
                S_RESULT: begin
                    if (i_ack) begin
                        state_q  <= S_IDLE;
                        caught_q <= 1'b0;
                        idx_q    <= '0;
                    end
                end
            endcase
        end
    end

    assign o_busy         = (state_q != S_IDLE);
    assign o_shake_left   = (state_q == S_SHAKE) && (frame_q <  HALF_FRAME);
    assign o_shake_right  = (state_q == S_SHAKE) && (frame_q >= HALF_FRAME);
    assign o_shake_idx    = idx_q;
    assign o_result_valid = (state_q == S_RESULT);
    assign o_caught       = caught_q;

endmodule

// File: tb/tb_catch_judge.sv
// Directed and LFSR-scoreboarded bench for catch_judge.
// Expected outputs come from a frame timeline and an independent LFSR model.
module tb_catch_judge;

    localparam int SF = 16;
    localparam int NS = 3;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_refresh;
    logic       i_collision_done;
    logic [7:0] i_catch_rate;
    logic       i_ack;
    logic       o_busy;
    logic       o_shake_left;
    logic       o_shake_right;
    logic [1:0] o_shake_idx;
    logic       o_result_valid;
    logic       o_caught;

    int tests = 0;
    int fails = 0;

    logic [15:0] m_lfsr;
    int          cyc;

    typedef struct {
        logic       caught;
        logic [1:0] idx;
        int         edge_c;
    } exp_t;

    exp_t sb[$];

    catch_judge dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_refresh        (i_refresh),
        .i_collision_done (i_collision_done),
        .i_catch_rate     (i_catch_rate),
        .i_ack            (i_ack),
        .o_busy           (o_busy),
        .o_shake_left     (o_shake_left),
        .o_shake_right    (o_shake_right),
        .o_shake_idx      (o_shake_idx),
        .o_result_valid   (o_result_valid),
        .o_caught         (o_caught)
    );

    always #5 i_clk = ~i_clk;

    // Reference LFSR: x^16 + x^14 + x^13 + x^11 + 1, shifting left
    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_lfsr <= 16'hACE1;
            cyc    <= 0;
        end else begin
            m_lfsr <= {m_lfsr[14:0],
                       m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            cyc    <= cyc + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {o_busy, o_shake_left, o_shake_right, o_shake_idx,
                o_result_valid, o_caught};
    endfunction

    // One capture attempt. Caller is #1 after a clock edge with
    // i_collision_done low for at least two cycles.
    task automatic attempt(input logic [7:0] rate, input int p,
                           input bit disturb, input int hold,
                           output int n_left, output int n_pause,
                           output int n_valid, output int res_ticks,
                           output logic last_caught);
        int         n0, base, nxt, shk, e_r, ack_e, limit, m, c, t, ph, w;
        logic [7:0] s, samp_exp;
        logic       done_draw, chk_samp, prev_left, prev_valid, prev_pause;
        logic       in_pause, ex_caught;
        logic [1:0] ex_idx;
        logic [6:0] exp_v;
        exp_t       e;
        n_left = 0; n_pause = 0; n_valid = 0; res_ticks = -1;
        last_caught = 1'bx;
        i_catch_rate = rate;
        n0 = cyc; base = n0 + 2; nxt = base; shk = 0;
        e_r = -1; ack_e = -1; done_draw = 0;
        ex_caught = 0; ex_idx = 0;
        limit = base + p * 2 * NS * SF + hold + 8;
        prev_left = 0; prev_valid = 0; prev_pause = 0;
        while (ack_e < 0 || cyc < ack_e + 2) begin
            if (cyc >= limit) begin
                tests++;
                fails++;
                $error("FAIL timeout: observed cycle %0d expected below %0d",
                       cyc, limit);
                break;
            end
            m = cyc;
            i_collision_done = (m + 1 <= n0 + p) ||
                (disturb && m + 1 > base + 3 * p && m + 1 <= base + 4 * p);
            i_refresh = (m + 1 >= base) && ((m + 1 - base) % p == 0);
            i_ack = (ack_e >= 0 && m + 1 == ack_e) ||
                (disturb && m + 1 == base + p * (SF + 3) + 1);
            chk_samp = 0;
            if (!done_draw && m + 1 == nxt) begin
                s = m_lfsr[7:0];
                samp_exp = s;
                chk_samp = 1;
                if (!(s < rate || rate == 8'hFF) || shk == NS - 1) begin
                    done_draw = 1;
                    e_r = base + p * (2 * shk + 1) * SF;
                    ack_e = e_r + 1 + hold;
                    ex_caught = (s < rate || rate == 8'hFF);
                    ex_idx = 2'(shk);
                    e.caught = ex_caught;
                    e.idx = ex_idx;
                    e.edge_c = e_r;
                    sb.push_back(e);
                end else begin
                    shk++;
                    nxt = base + p * 2 * shk * SF;
                end
            end
            @(posedge i_clk);
            #1;
            c = cyc;
            if (chk_samp) chk("sample", 32'(dut.sample_q), 32'(samp_exp));
            if (c < base) begin
                exp_v = '0;
            end else if (e_r >= 0 && c >= ack_e) begin
                exp_v = '0;
            end else if (e_r >= 0 && c >= e_r) begin
                exp_v = {1'b1, 1'b0, 1'b0, ex_idx, 1'b1, ex_caught};
            end else begin
                t = (c - base) / p;
                ph = t / SF;
                w = t % SF;
                exp_v = {1'b1, (ph % 2 == 0) && (w < SF / 2),
                         (ph % 2 == 0) && (w >= SF / 2), 2'(ph / 2),
                         1'b0, 1'b0};
            end
            chk("outputs", 32'(outs()), 32'(exp_v));
            in_pause = o_busy && !o_shake_left && !o_shake_right &&
                       !o_result_valid;
            if (o_shake_left && !prev_left) n_left++;
            if (in_pause && !prev_pause) n_pause++;
            if (o_result_valid) n_valid++;
            if (o_result_valid && !prev_valid) begin
                res_ticks = (c - base) / p;
                last_caught = o_caught;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $error("FAIL sb_empty: observed result expected none");
                end else begin
                    e = sb.pop_front();
                    chk("res_caught", 32'(o_caught), 32'(e.caught));
                    chk("res_idx", 32'(o_shake_idx), 32'(e.idx));
                    chk("res_edge", c, e.edge_c);
                end
            end
            prev_left = o_shake_left;
            prev_valid = o_result_valid;
            prev_pause = in_pause;
        end
        i_collision_done = 0;
        i_refresh = 0;
        i_ack = 0;
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        int   nl, np, nv, rt;
        logic lc;
        i_rst_n = 0;
        i_refresh = 0;
        i_collision_done = 0;
        i_catch_rate = 0;
        i_ack = 0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_outs", 32'(outs()), 0);
        chk("rst_lfsr", 32'(dut.u_lfsr.q), 32'h0000ACE1);
        #3 i_rst_n = 1;
        @(posedge i_clk);
        #1;
        repeat (2) @(posedge i_clk);
        #1;

        // always pass: 3 shakes, 2 pauses, 80 ticks, held 21 cycles
        attempt(8'hFF, 10, 0, 20, nl, np, nv, rt, lc);
        chk("pass_shakes", nl, 3);
        chk("pass_pauses", np, 2);
        chk("pass_ticks", rt, 80);
        chk("pass_hold", nv, 21);
        chk("pass_caught", 32'(lc), 1);

        // always fail: single shake, no pause, 16 ticks
        attempt(8'h00, 10, 0, 5, nl, np, nv, rt, lc);
        chk("fail_shakes", nl, 1);
        chk("fail_pauses", np, 0);
        chk("fail_ticks", rt, 16);
        chk("fail_caught", 32'(lc), 0);

        // stray collision_done in shake and ack in pause change nothing
        attempt(8'hFF, 4, 1, 3, nl, np, nv, rt, lc);
        chk("dist_shakes", nl, 3);
        chk("dist_pauses", np, 2);
        chk("dist_ticks", rt, 80);
        chk("dist_caught", 32'(lc), 1);

        // ack on the result entry cycle: one-cycle valid pulse
        attempt(8'h00, 2, 0, 0, nl, np, nv, rt, lc);
        chk("sameack_len", nv, 1);
        chk("sameack_ticks", rt, 16);

        // reset during shake 1
        i_catch_rate = 8'hFF;
        i_collision_done = 1;
        @(posedge i_clk);
        #1;
        chk("lat_1clk", 32'(o_busy), 0);
        @(posedge i_clk);
        #1;
        chk("lat_2clk", 32'({o_busy, o_shake_left}), 32'b11);
        i_refresh = 1;
        repeat (SF) @(posedge i_clk);
        #1;
        i_collision_done = 0;
        repeat (40 - SF) @(posedge i_clk);
        #1;
        chk("pre_rst_idx", 32'(o_shake_idx), 1);
        #2 i_rst_n = 0;
        #1;
        chk("async_rst_outs", 32'(outs()), 0);
        chk("async_rst_lfsr", 32'(dut.u_lfsr.q), 32'h0000ACE1);
        i_refresh = 0;
        #1 i_rst_n = 1;
        #1;
        chk("post_rst_lfsr", 32'(dut.u_lfsr.q), 32'h0000ACE1);
        @(posedge i_clk);
        #1;
        chk("post_rst_idle", 32'(outs()), 0);
        repeat (2) @(posedge i_clk);
        #1;
        attempt(8'hFF, 2, 0, 2, nl, np, nv, rt, lc);
        chk("post_rst_shakes", nl, 3);

        // random outcomes against the LFSR model
        for (int k = 0; k < 200; k++) begin
            attempt(8'h80, 2, 0, k % 3, nl, np, nv, rt, lc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/catch_judge.md
# catch_judge

Downstream of `collision`, the block that resolves a capture attempt. It waits for the ball-hit sequence to finish, then plays up to `NUM_SHAKES` frame-timed ball shakes and draws from a free-running LFSR to decide the outcome. It presents a held catch/escape result to the game-flow controller until that controller acknowledges it. All animation timing counts `i_refresh` frame ticks, the same tick used by `collision`.

## Interface
- `SHAKE_FRAMES`, 16: frames per shake phase and per pause phase; must be even and at least 2.
- `NUM_SHAKES`, 3: shakes needed for a catch, range 1–3.
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `i_clk` input 1: system clock.
- `i_rst_n` input 1: reset. One clock; reset is asynchronous and active-low.
- `i_refresh` input 1: one-cycle frame tick.
- `i_collision_done` input 1: from `collision`; high for exactly one frame period when the hit animation ends.
- `i_catch_rate` input 8: pass threshold per shake; 8'h00 always fails, 8'hFF always passes.
- `i_ack` input 1: one-cycle result acknowledge from the game FSM.
- `o_busy` input-side status, output 1: high in any state other than IDLE.
- `o_shake_left` output 1: ball sprite offset left.
- `o_shake_right` output 1: ball sprite offset right.
- `o_shake_idx` output 2: current shake number, 0-based.
- `o_result_valid` output 1: result held.
- `o_caught` output 1: outcome, valid only while `o_result_valid` is high.

## Operation
- States: S_IDLE, S_SHAKE, S_PAUSE, S_RESULT.
- LFSR: 16-bit Fibonacci, taps 16, 14, 13, 11. It steps every `i_clk` cycle in every state, reset to `LFSR_SEED`.
- S_IDLE → S_SHAKE on a rising edge of `i_collision_done`.
  - Edge detect uses a registered copy of `i_collision_done`.
  - On entry: `shake_idx` = 0, `frame_cnt` = 0, `r_sample` ← LFSR[7:0].
- Shake pass rule: `(r_sample < i_catch_rate) || (i_catch_rate == 8'hFF)`. Compare is unsigned 8-bit, evaluated on the S_SHAKE exit tick.
- S_SHAKE:
  - `frame_cnt` increments on each `i_refresh`.
  - `o_shake_left` is high while `frame_cnt` < `SHAKE_FRAMES`/2; `o_shake_right` is high otherwise.
  - On `i_refresh` with `frame_cnt` == `SHAKE_FRAMES`-1:
    - fail → S_RESULT with `caught` = 0.
    - pass and `shake_idx` == `NUM_SHAKES`-1 → S_RESULT with `caught` = 1.
    - otherwise → S_PAUSE.
  - `frame_cnt` clears on exit.
- S_PAUSE:
  - Both shake outputs are low.
  - On `i_refresh` with `frame_cnt` == `SHAKE_FRAMES`-1 → S_SHAKE, `shake_idx`+1, `frame_cnt` = 0, `r_sample` ← LFSR[7:0] (fresh draw).
- S_RESULT:
  - `o_result_valid` = 1 and `o_caught` is held.
  - `i_ack` → S_IDLE on the next edge; `o_result_valid` and `o_caught` clear.
- `i_collision_done` edges outside S_IDLE are ignored and never queued.
- `i_ack` outside S_RESULT is ignored.
- `i_catch_rate` is not latched; it is sampled at each decision tick.

## Timing
- Reset values:
  - state S_IDLE
  - all outputs 0
  - `frame_cnt`, `shake_idx`, `r_sample` = 0
  - LFSR = `LFSR_SEED`
  - registered `collision_done` = 0
- All outputs are registered or decoded from registered state only; no combinational input→output paths.
- Start latency: S_SHAKE is entered 2 clocks after `i_collision_done` rises (edge-detect register, then state register). `o_busy` and `o_shake_left` are high in that cycle.
- Frame `i_refresh` arriving in the same cycle as the state entry is not counted; counting begins with the next tick.
- A full catch lasts (2·`NUM_SHAKES`−1)·`SHAKE_FRAMES` refresh ticks from the first counted tick to `o_result_valid`. With defaults that is 80.
- A fail on shake k (0-based) gives the result after (2k+1)·`SHAKE_FRAMES` ticks.
- `i_ack` arriving on the same cycle as entry into S_RESULT is honoured, giving a one-cycle `o_result_valid` pulse.
- Asynchronous reset mid-operation returns everything to the reset values immediately; no result is emitted.

## Structure
- `catch_pkg` holds:
  - the `catch_state_e` enum (2 bits)
  - the LFSR tap mask constant
  - the default `SHAKE_FRAMES` / `NUM_SHAKES` / `LFSR_SEED` values
- Sub-module `lfsr16` has ports clk, rst_n, seed parameter, and 16-bit `q`, always enabled. It is reused later for wild-encounter randomness.
- `catch_judge` holds the FSM, `frame_cnt` (width $clog2(`SHAKE_FRAMES`)), `shake_idx`, `r_sample`, and the edge-detect register.

## Test plan
- Always-pass run: reset, `i_catch_rate`=8'hFF, pulse `i_collision_done` high for one frame, `i_refresh` every 10 clocks.
  - Required: exactly 3 left/right shake phases and 2 pauses.
  - `o_result_valid`=1 and `o_caught`=1 after 80 counted ticks.
  - The result holds until `i_ack`, then all outputs return to 0.
- Always-fail run: `i_catch_rate`=8'h00.
  - Required: a single shake with `o_shake_idx`=0.
  - `o_result_valid`=1 and `o_caught`=0 after 16 ticks; no S_PAUSE is ever observed.
- Random outcome: `i_catch_rate`=8'h80, `LFSR_SEED` default; a scoreboard models the LFSR cycle-exactly.
  - Required: the sampled bytes and the resulting number of shakes and `o_caught` match the model over 200 attempts.
- Ignored stimulus: second `i_collision_done` pulse during S_SHAKE, and `i_ack` during S_PAUSE.
  - Required: no restart, `shake_idx` unchanged, and the final result identical to an undisturbed run.
- Reset mid-shake: assert `i_rst_n`=0 during shake 1.
  - Required: all outputs 0 asynchronously.
  - After release, LFSR = 16'hACE1 and a new `i_collision_done` starts from `o_shake_idx`=0.
- Same-cycle `i_ack`: assert `i_ack` on the S_RESULT entry cycle.
  - Required: `o_result_valid` high for exactly 1 clock, then S_IDLE.
